// File: rtl/bpred_btb_sat.sv
// Direct-mapped tagged BTB with saturating direction counters, F-stage prediction and E-stage resolve/train.
// Optional macro BPRED_GSHARE_EN: XOR the counter index with a global branch history register.
module bpred_btb_sat #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 1024,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_F,
  input  logic [XLEN-1:0] pc4_F,
  output logic [XLEN-1:0] pc_next,
  output logic            taken_F,
  output logic [XLEN-1:0] pred_target_F,
  input  logic            branch_E,
  input  logic            jump_E,
  input  logic            branch,
  input  logic            taken_E,
  input  logic [XLEN-1:0] pred_target_E,
  input  logic [XLEN-1:0] pc_E,
  input  logic [XLEN-1:0] pc4_E,
  input  logic [XLEN-1:0] pc_target,
  output logic            flush,
  output logic [XLEN-1:0] pc_restore
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]  r_target [ENTRIES];
  logic             r_jmp    [ENTRIES];
  logic [CTR_W-1:0] r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_idxF, w_idxE, w_cidxF, w_cidxE;
  logic [TAG_W-1:0] w_tagF, w_tagE;
  logic             w_hitF, w_hitE, w_ctl, w_actual, w_mispredict;
  logic [CTR_W-1:0] w_ctrE, w_ctrInc, w_ctrDec;

  assign w_idxF = pc_F[IDX_W+1:2];
  assign w_idxE = pc_E[IDX_W+1:2];
  assign w_tagF = pc_F[IDX_W+TAG_W+1:IDX_W+2];
  assign w_tagE = pc_E[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BPRED_GSHARE_EN
  logic [IDX_W-1:0] r_ghr;
  logic [IDX_W:0]   w_ghrShift;

  assign w_ghrShift = {r_ghr, w_actual};
  assign w_cidxF    = w_idxF ^ r_ghr;
  assign w_cidxE    = w_idxE ^ r_ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (branch_E) begin
      r_ghr <= w_ghrShift[IDX_W-1:0];
    end
  end
`else
  assign w_cidxF = w_idxF;
  assign w_cidxE = w_idxE;
`endif

  assign w_hitF        = r_valid[w_idxF] && (r_tag[w_idxF] == w_tagF);
  assign taken_F       = w_hitF & (r_jmp[w_idxF] | r_ctr[w_cidxF][CTR_W-1]);
  assign pred_target_F = r_target[w_idxF];
  assign pc_next       = taken_F ? r_target[w_idxF] : pc4_F;

  // Flush covers direction, target and alias (taken prediction on a non-control instruction) mispredicts.
  assign w_ctl        = branch_E | jump_E;
  assign w_actual     = jump_E | (branch_E & branch);
  assign w_mispredict = (w_ctl & (w_actual != taken_E))
                      | (w_ctl & w_actual & taken_E & (pred_target_E != pc_target))
                      | (taken_E & ~w_ctl);
  assign flush        = rst_n & w_mispredict;
  assign pc_restore   = w_actual ? pc_target : pc4_E;

  assign w_hitE   = r_valid[w_idxE] && (r_tag[w_idxE] == w_tagE);
  assign w_ctrE   = r_ctr[w_cidxE];
  assign w_ctrInc = (w_ctrE == CTR_MAX) ? w_ctrE : w_ctrE + CTR_W'(1);
  assign w_ctrDec = (w_ctrE == '0)      ? w_ctrE : w_ctrE - CTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WNT;
      end
    end else if (jump_E) begin
      r_valid[w_idxE] <= 1'b1;
      r_ctr[w_cidxE]  <= CTR_MAX;
    end else if (branch_E) begin
      if (w_hitE) begin
        r_ctr[w_cidxE] <= branch ? w_ctrInc : w_ctrDec;
      end else if (branch) begin
        r_valid[w_idxE] <= 1'b1;
        r_ctr[w_cidxE]  <= CTR_WT;
      end
    end
  end

  // Payload fields are meaningless while valid=0, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (jump_E) begin
        r_tag[w_idxE]    <= w_tagE;
        r_target[w_idxE] <= pc_target;
        r_jmp[w_idxE]    <= 1'b1;
      end else if (branch_E) begin
        if (w_hitE) begin
          r_jmp[w_idxE] <= 1'b0;
          if (branch) begin
            r_target[w_idxE] <= pc_target;
          end
        end else if (branch) begin
          r_tag[w_idxE]    <= w_tagE;
          r_target[w_idxE] <= pc_target;
          r_jmp[w_idxE]    <= 1'b0;
        end
      end
    end
  end

endmodule
